striping_sched: RTL

Sequencing controller in front of the TX byte-striping stage, clocked in the `clk_2f` domain. It accepts 32-bit words from upstream with a valid/ready handshake. It assigns each accepted word to lane 0 or lane 1 (round-robin in two-lane mode, lane 0 only in single-lane mode) and presents the word, its valid, and the lane selector, registered, to the striper. It also applies per-lane backpressure, keeps lane words paired across enable and mode changes, and reports per-lane word counts and a sticky stall-timeout error.

---
 rtl/phy_tx_pkg.sv | 13 +
 rtl/wrap_counter.sv | 31 +++
 rtl/striping_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/phy_tx_pkg.sv
// Shared TX PHY definitions: scheduler state encoding and lane indices.
package phy_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/wrap_counter.sv
// Free-running wrap-around counter with increment enable.
module wrap_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/striping_sched.sv
// Lane scheduler ahead of the TX byte striper: round-robin lane
// assignment, pair-preserving stop/mode changes, stall timeout.
module striping_sched
    import phy_tx_pkg::*;
#(
    parameter int STALL_MAX = 15,
    parameter int CNT_W     = 16
) (
    input  logic             clk_2f,
    input  logic             reset_L,
    input  logic             enable,
    input  logic             lane_mode,
    input  logic             valid_in,
    input  logic [31:0]      data_in,
    output logic             ready_out,
    input  logic [1:0]       lane_full,
    output logic [31:0]      data_out,
    output logic             valid_out,
    output logic             selector,
    output logic [CNT_W-1:0] word_cnt0,
    output logic [CNT_W-1:0] word_cnt1,
    output logic             stall_err
);

    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STALL_MAX);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          mode_q, mode_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d, stall_inc;
    logic          err_q, err_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          sel_q, sel_d;
    logic          accept;

    assign ready_out = (state_q == RUN) & ~lane_full[ptr_q];
    assign accept    = valid_in & ready_out;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = mode_q ? ~ptr_q : LANE0;
        end
        // Mode only changes between pairs, never after a lane-0 word.
        mode_d = (ptr_d == LANE0) ? lane_mode : mode_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (lane_full[ptr_q]) begin
                    state_d = STALL;
                end else if (!enable && ptr_d == LANE0) begin
                    state_d = IDLE;
                end
            end
            STALL: begin
                if (!lane_full[ptr_q]) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_inc   = (stall_cnt_q == SMAX) ? stall_cnt_q
                                            : stall_cnt_q + SW'(1);
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;
        if (state_q == STALL) begin
            stall_cnt_d = stall_inc;
            err_d       = err_q | (stall_inc == SMAX);
        end
        if (state_d == RUN) begin
            stall_cnt_d = '0;
        end
    end

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = accept;
        if (accept) begin
            data_d = data_in;
            sel_d  = ptr_q;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            ptr_q       <= LANE0;
            mode_q      <= 1'b0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sel_q       <= LANE0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mode_q      <= mode_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
        end
    end

    wrap_counter #(.W(CNT_W)) u_cnt0 (
        .clk_i  (clk_2f),
        .rst_ni (reset_L),
        .inc_i  (accept & (ptr_q == LANE0)),
        .cnt_o  (word_cnt0)
    );

    wrap_counter #(.W(CNT_W)) u_cnt1 (
        .clk_i  (clk_2f),
        .rst_ni (reset_L),
        .inc_i  (accept & (ptr_q == LANE1)),
        .cnt_o  (word_cnt1)
    );

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign selector  = sel_q;
    assign stall_err = err_q;

endmodule
